// File: rtl/wb_pkg.sv
// Shared types and widths for the write-back path into the register file.
package wb_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   // One pending register-file write: destination register and its data.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests. Pointers wrap naturally; full and
// empty come from a separate occupancy count one bit wider than the pointers.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  wb_req_t                  din,
   input  logic                     pop,
   output wb_req_t                  head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   wb_req_t           mem_q [DEPTH];
   logic [AW-1:0]     wptr_q;
   logic [AW-1:0]     rptr_q;
   logic [AW:0]       count_q;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage write; the data array carries no reset.
   // NOTE: storage is left unreset on purpose -- the count alone decides which
   // entries are valid, so clearing the array would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= din;
      end
   end

   // Pointer and occupancy update; simultaneous push and pop keep the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges non-stallable ALU results with buffered load
// results onto the single register-file write port, with a starvation guard.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [REG_AW-1:0] ld_rd,
   input  logic [XLEN-1:0]   ld_data,
   output logic              wr,
   output logic [REG_AW-1:0] wadd,
   output logic [XLEN-1:0]   datain,
   output logic              stall,
   output logic              ld_pending
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_MAX + 1);

   wb_req_t           fifo_head;
   wb_req_t           ld_req;
   logic              fifo_full;
   logic              fifo_empty;
   logic [AW:0]       fifo_count;
   logic              ld_push;
   logic              alu_win;
   logic              fifo_pop;

   logic              wr_q, wr_d;
   logic [REG_AW-1:0] wadd_q, wadd_d;
   logic [XLEN-1:0]   datain_q, datain_d;
   logic              stall_q, stall_d;
   logic              pend_q, pend_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [AW:0]       count_nx;

   assign ld_ready = !fifo_full;
   // Loads to x0 complete the handshake but are never buffered.
   assign ld_push  = ld_valid && !fifo_full && (ld_rd != '0);
   // ALU writes to x0 are suppressed and leave the slot free for a drain.
   assign alu_win  = alu_valid && (alu_rd != '0);
   assign fifo_pop = !alu_win && !fifo_empty;
   assign ld_req   = '{rd: ld_rd, data: ld_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ld_push),
      .din   (ld_req),
      .pop   (fifo_pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Next-state for the write port, starvation counter and status flags.
   // NOTE: every output of this block is given a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      wr_d     = 1'b0;
      wadd_d   = wadd_q;
      datain_d = datain_q;
      starve_d = starve_q;
      count_nx = fifo_count;

      if (alu_win) begin
         wr_d     = 1'b1;
         wadd_d   = alu_rd;
         datain_d = alu_data;
      end else if (fifo_pop) begin
         wr_d     = 1'b1;
         wadd_d   = fifo_head.rd;
         datain_d = fifo_head.data;
      end

      // A deferral is an ALU win while loads wait; any drain or empty clears.
      if (fifo_empty || fifo_pop) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end

      case ({ld_push, fifo_pop})
         2'b10:   count_nx = fifo_count + 1'b1;
         2'b01:   count_nx = fifo_count - 1'b1;
         default: count_nx = fifo_count;
      endcase

      stall_d = (starve_d == SW'(STARVE_MAX));
      pend_d  = (count_nx != '0);
   end

   // Registered write port, stall and load-pending flags.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q     <= 1'b0;
         wadd_q   <= '0;
         datain_q <= '0;
         stall_q  <= 1'b0;
         pend_q   <= 1'b0;
         starve_q <= '0;
      end else begin
         wr_q     <= wr_d;
         wadd_q   <= wadd_d;
         datain_q <= datain_d;
         stall_q  <= stall_d;
         pend_q   <= pend_d;
         starve_q <= starve_d;
      end
   end

   assign wr         = wr_q;
   assign wadd       = wadd_q;
   assign datain     = datain_q;
   assign stall      = stall_q;
   assign ld_pending = pend_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for single-cycle behaviour
// plus hand-written sequences for fill, same-cycle push/pop, wrap and reset.
module tb_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        wr;
   logic [4:0]  wadd;
   logic [31:0] datain;
   logic        stall;
   logic        ld_pending;

   int tests_run;
   int tests_failed;

   wb_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_rd      (ld_rd),
      .ld_data    (ld_data),
      .wr         (wr),
      .wadd       (wadd),
      .datain     (datain),
      .stall      (stall),
      .ld_pending (ld_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (got running, expected done)");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        av;
      logic [4:0]  ar;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  lr;
      logic [31:0] ldat;
      logic        e_rdy;
      logic        e_wr;
      logic [4:0]  e_wadd;
      logic [31:0] e_din;
      logic        e_stall;
      logic        e_pend;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid = v;
      alu_rd    = rd;
      alu_data  = d;
   endtask

   task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
      ld_valid = v;
      ld_rd    = rd;
      ld_data  = d;
   endtask

   task automatic check_wr(input string name, input logic [4:0] rd, input logic [31:0] d);
      check({name, ".wr"}, wr, 1'b1);
      check({name, ".wadd"}, wadd, rd);
      check({name, ".datain"}, datain, d);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_alu(1'b0, 5'd0, 32'd0);
      set_ld(1'b0, 5'd0, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      set_alu(1'b0, 5'd0, 32'd0);
      set_ld(1'b0, 5'd0, 32'd0);

      // Reset held for 3 cycles with random inputs.
      for (int i = 0; i < 3; i++) begin
         set_alu(1'($urandom), 5'($urandom), $urandom);
         set_ld(1'($urandom), 5'($urandom), $urandom);
         tick();
      end
      check("rst.wr", wr, 1'b0);
      check("rst.wadd", wadd, 5'd0);
      check("rst.datain", datain, 32'd0);
      check("rst.stall", stall, 1'b0);
      check("rst.ld_pending", ld_pending, 1'b0);
      check("rst.ld_ready", ld_ready, 1'b1);
      set_alu(1'b0, 5'd0, 32'd0);
      set_ld(1'b0, 5'd0, 32'd0);
      rst_n = 1'b1;
      tick();
      check("rst.idle_wr", wr, 1'b0);

      // Single-cycle vectors; ld_ready is checked before the edge, the rest after.
      //           av    ar     ad            lv    lr     ldat          rdy   wr    wadd   din           stall pend
      vecs[0]  = '{1'b1, 5'd5,  32'h00887000, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd5,  32'h00887000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd5,  32'h00887000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hDEADBEEF, 1'b1, 1'b0, 5'd5,  32'h00887000, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd7,  32'hDEADBEEF, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hCAFEF00D, 1'b1, 1'b0, 5'd7,  32'hDEADBEEF, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd7,  32'hDEADBEEF, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 5'd0,  32'h77777777, 1'b1, 5'd9,  32'h00000099, 1'b1, 1'b0, 5'd7,  32'hDEADBEEF, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 5'd0,  32'h88888888, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd9,  32'h00000099, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 5'd3,  32'h00000033, 1'b1, 5'd4,  32'h00000044, 1'b1, 1'b1, 5'd3,  32'h00000033, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 5'd6,  32'h00000066, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd6,  32'h00000066, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd4,  32'h00000044, 1'b0, 1'b0};

      for (int i = 0; i < 12; i++) begin
         set_alu(vecs[i].av, vecs[i].ar, vecs[i].ad);
         set_ld(vecs[i].lv, vecs[i].lr, vecs[i].ldat);
         check($sformatf("vec%0d.ld_ready", i), ld_ready, vecs[i].e_rdy);
         tick();
         check($sformatf("vec%0d.wr", i), wr, vecs[i].e_wr);
         check($sformatf("vec%0d.wadd", i), wadd, vecs[i].e_wadd);
         check($sformatf("vec%0d.datain", i), datain, vecs[i].e_din);
         check($sformatf("vec%0d.stall", i), stall, vecs[i].e_stall);
         check($sformatf("vec%0d.ld_pending", i), ld_pending, vecs[i].e_pend);
      end
      set_alu(1'b0, 5'd0, 32'd0);
      set_ld(1'b0, 5'd0, 32'd0);
      tick();

      // Fill: four loads under continuous ALU traffic, then stall and drain.
      for (int i = 0; i < 4; i++) begin
         set_alu(1'b1, 5'(i + 1), 32'h100 + i);
         set_ld(1'b1, 5'(10 + i), 32'hA10 + i);
         check($sformatf("fill%0d.ld_ready_pre", i), ld_ready, 1'b1);
         tick();
         check_wr($sformatf("fill%0d", i), 5'(i + 1), 32'h100 + i);
         check($sformatf("fill%0d.stall", i), stall, (i == 3) ? 1'b1 : 1'b0);
         check($sformatf("fill%0d.ld_pending", i), ld_pending, 1'b1);
      end
      check("fill.ld_ready_full", ld_ready, 1'b0);
      // ALU keeps winning while stalled; the held load must not be accepted.
      set_alu(1'b1, 5'd5, 32'h105);
      set_ld(1'b1, 5'd14, 32'hA14);
      tick();
      check_wr("fill_ovr", 5'd5, 32'h105);
      check("fill_ovr.stall", stall, 1'b1);
      check("fill_ovr.ld_ready", ld_ready, 1'b0);
      // ALU drops: first drain, space frees, held load still offered.
      set_alu(1'b0, 5'd0, 32'd0);
      tick();
      check_wr("drain0", 5'd10, 32'hA10);
      check("drain0.stall", stall, 1'b0);
      check("drain0.ld_ready", ld_ready, 1'b1);
      // Push of the held load coincides with the next pop.
      tick();
      check_wr("drain1", 5'd11, 32'hA11);
      check("drain1.ld_ready", ld_ready, 1'b1);
      set_ld(1'b0, 5'd0, 32'd0);
      for (int i = 2; i < 5; i++) begin
         tick();
         check_wr($sformatf("drain%0d", i), 5'(10 + i), 32'hA10 + i);
      end
      check("drain.ld_pending_end", ld_pending, 1'b0);
      tick();
      check("drain.idle_wr", wr, 1'b0);

      // Same-cycle push and pop at count 2; order must be preserved.
      set_alu(1'b1, 5'd1, 32'h201);
      set_ld(1'b1, 5'd20, 32'hB20);
      tick();
      set_alu(1'b1, 5'd2, 32'h202);
      set_ld(1'b1, 5'd21, 32'hB21);
      tick();
      set_alu(1'b0, 5'd0, 32'd0);
      set_ld(1'b1, 5'd22, 32'hB22);
      tick();
      check_wr("pp0", 5'd20, 32'hB20);
      check("pp0.ld_pending", ld_pending, 1'b1);
      set_ld(1'b0, 5'd0, 32'd0);
      tick();
      check_wr("pp1", 5'd21, 32'hB21);
      check("pp1.ld_pending", ld_pending, 1'b1);
      tick();
      check_wr("pp2", 5'd22, 32'hB22);
      check("pp2.ld_pending", ld_pending, 1'b0);
      tick();
      check("pp.idle_wr", wr, 1'b0);

      // Pointer wrap: ten back-to-back loads, no ALU traffic.
      for (int i = 0; i < 11; i++) begin
         if (i < 10) set_ld(1'b1, 5'(16 + i), 32'hA0000000 + i);
         else        set_ld(1'b0, 5'd0, 32'd0);
         tick();
         if (i >= 1) check_wr($sformatf("wrap%0d", i - 1), 5'(16 + i - 1), 32'hA0000000 + i - 1);
      end
      tick();
      check("wrap.idle_wr", wr, 1'b0);

      // Reset asserted mid-drain must discard buffered loads.
      for (int i = 0; i < 3; i++) begin
         set_alu(1'b1, 5'(i + 1), 32'h300 + i);
         set_ld(1'b1, 5'(30 + i), 32'hC30 + i);
         tick();
      end
      set_alu(1'b0, 5'd0, 32'd0);
      set_ld(1'b0, 5'd0, 32'd0);
      tick();
      check_wr("mid", 5'd30, 32'hC30);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst.wr", wr, 1'b0);
      check("mid_rst.wadd", wadd, 5'd0);
      check("mid_rst.ld_pending", ld_pending, 1'b0);
      check("mid_rst.ld_ready", ld_ready, 1'b1);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post_rst%0d.wr", i), wr, 1'b0);
         check($sformatf("post_rst%0d.ld_pending", i), ld_pending, 1'b0);
      end

      do_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the 32-bit RISC core. It sits directly upstream of the register file and drives its single write port (`wr`, `wadd`, `datain`). It merges two result sources: single-cycle ALU results, which cannot be back-pressured, and variable-latency load results, which use a valid/ready handshake. Load results are buffered in a small FIFO and drained into free write-port cycles, with a starvation guard that briefly stalls the ALU path.

## Interface
- `DEPTH`, 4: load FIFO entries; power of two, ≥2.
- `STARVE_MAX`, 3: consecutive deferred cycles before `stall` asserts; ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result valid this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `ld_valid`  in  1  load result offered.
- `ld_ready`  out  1  load result accepted when `ld_valid && ld_ready`.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  32  load data.
- `wr`  out  1  register-file write enable (registered).
- `wadd`  out  5  register-file write address (registered).
- `datain`  out  32  register-file write data (registered).
- `stall`  out  1  registered; decode must hold ALU issue while high.
- `ld_pending`  out  1  registered; FIFO non-empty; decode interlock for load-use.

## Operation
- Reset values: `wr`=0, `wadd`=0, `datain`=0, `stall`=0, `ld_pending`=0. FIFO count is 0 and the starvation counter is 0. Reset mid-operation discards all buffered loads.
- `ld_ready` = !full. It is combinational from the FIFO count and is 1 out of reset.
- Load accept: on a handshake with `ld_rd`≠0, push {rd, data}. With `ld_rd`=0, the handshake completes and the data is dropped without a push.
- Arbitration per cycle, with a registered decision presented next cycle:
  - If `alu_valid` and `alu_rd`≠0: the ALU wins.
  - Else if the FIFO is non-empty: pop the head and write it.
  - Else: `wr`=0.
- An ALU write with `alu_rd`=0 is suppressed (`wr`=0) and counts as an idle slot, so the FIFO head may drain in that cycle.
- When no write occurs, `wadd`/`datain` hold their previous values.
- Starvation counter:
  - Increments (saturating at `STARVE_MAX`) each cycle the FIFO is non-empty and the ALU wins.
  - Clears to 0 on any pop, and whenever the FIFO is empty.
  - `stall` is registered as (counter == `STARVE_MAX`).
- If `alu_valid` arrives while `stall` is high, the ALU still wins (protocol violation by decode). The counter stays saturated.
- Push and pop may happen in the same cycle. On a simultaneous push and pop, count is unchanged; the popped entry is the older head.
- Ordering across channels is not enforced. Decode uses `ld_pending` to avoid write-after-write and read-after-write hazards against pending loads.
- FIFO pointers are log2(`DEPTH`) bits and wrap naturally; full/empty is derived from a separate count of log2(`DEPTH`)+1 bits.

## Timing
- ALU path latency is 1: `alu_valid` in cycle N gives `wr`=1 in cycle N+1, and the register file captures the write at the end of N+1.
- Load path latency is 2 minimum: handshake in cycle N, entry at the FIFO head in N+1, `wr`=1 in N+2 (only if there is no ALU write in N+1).
- `ld_ready` may fall in the same cycle the FIFO becomes full after an edge. A push while full cannot occur.
- `ld_pending` reflects the FIFO count after the edge, so it lags `ld_ready` by the same edge.
- `stall` follows `STARVE_MAX` consecutive deferrals by one cycle. The first non-ALU cycle after that drains the head.

## Structure
- Shared package `wb_pkg` holds:
  - `XLEN`=32 and `REG_AW`=5.
  - The typedef `wb_req_t` {`rd`[4:0], `data`[31:0]}.
- Sub-module `wb_fifo`: parameterised synchronous FIFO of `wb_req_t` with `push`, `pop`, `full`, `empty`, `head`, and active-low asynchronous reset.
- The top level contains arbitration, the starvation counter, and the output registers.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs. Required: `wr`=0, `wadd`=0, `datain`=0, `stall`=0, `ld_pending`=0, `ld_ready`=1. Assert reset mid-drain; the FIFO must be empty afterwards.
- ALU only: `alu_valid`=1, rd=5, data=0x00887000 in cycle N. Required: `wr`=1, `wadd`=5, `datain`=0x00887000 in N+1. rd=0 must give `wr`=0.
- Load only: handshake rd=7, data=0xDEADBEEF. Required: `wr`=1, `wadd`=7 two cycles later, and `ld_pending` is 1 for exactly one cycle. A load with rd=0 is accepted and never written.
- Fill: issue 4 loads while `alu_valid`=1 every cycle. Required:
  - `ld_ready` drops after the 4th push.
  - `stall`=1 three cycles after the first deferral.
  - Dropping `alu_valid` then drains the entries in order.
- Same-cycle events: push while popping with count=2. Required: count stays 2 and FIFO order is preserved. Push at full with `ld_valid` held: no accept until a pop frees space.
- Pointer wrap: stream 10 loads with no ALU traffic. Required: writes emerge in order with correct rd/data across the pointer wrap.
